// File: rtl/bip_pkg.sv
// Shared encodings and default widths for the BIP1 run controller and the control unit.
package bip_pkg;
   localparam int DEF_NB_INSTRUC = 16;
   localparam int DEF_NB_OPCODE  = 5;
   localparam int DEF_NB_ADDR    = 11;
   localparam int DEF_NB_CYCLES  = 16;

   localparam logic [4:0] OPC_HLT = 5'b00000;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOADED = 3'd1,
      ST_RUN    = 3'd2,
      ST_STEP   = 3'd3,
      ST_HALT   = 3'd4
   } state_t;
endpackage

// File: rtl/bip_run_ctrl_if.sv
// Loader stream into the run controller: valid/ready words with an end-of-program marker.
interface bip_run_ctrl_if
   import bip_pkg::*;
#(
   parameter int NB_INSTRUC = DEF_NB_INSTRUC
);
   logic                  ld_valid;
   logic [NB_INSTRUC-1:0] ld_data;
   logic                  ld_last;
   logic                  ld_ready;

   modport master (output ld_valid, output ld_data, output ld_last, input ld_ready);
   modport slave  (input ld_valid, input ld_data, input ld_last, output ld_ready);
endinterface

// File: rtl/bip_sat_counter.sv
// Saturating up-counter, registered, one-cycle latency; clear wins over inc; no backpressure.
module bip_sat_counter #(
   parameter int NB_CYCLES = 16
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic                 inc,
   output logic [NB_CYCLES-1:0] count
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + NB_CYCLES'(1);
      end
   end
endmodule

// File: rtl/bip_run_ctrl.sv
// Run controller: loads program memory, then runs/steps the CPU until HLT; registered control, write port follows the beat combinationally.
// Loader is backpressured (ld_ready=0) everywhere except IDLE.
module bip_run_ctrl
   import bip_pkg::*;
#(
   parameter int NB_INSTRUC = DEF_NB_INSTRUC,
   parameter int NB_OPCODE  = DEF_NB_OPCODE,
   parameter int NB_ADDR    = DEF_NB_ADDR,
   parameter int NB_CYCLES  = DEF_NB_CYCLES
)(
   input  logic                  clk,
   input  logic                  rst_n,
   bip_run_ctrl_if.slave         ld,
   input  logic                  start,
   input  logic                  step_mode,
   input  logic                  step,
   input  logic                  clear,
   input  logic [NB_INSTRUC-1:0] instruc,
   input  logic [NB_ADDR-1:0]    pc,
   output logic                  pmem_we,
   output logic [NB_ADDR-1:0]    pmem_addr,
   output logic [NB_INSTRUC-1:0] pmem_data,
   output logic                  cpu_rst,
   output logic                  cpu_en,
   output logic                  done,
   output logic [NB_CYCLES-1:0]  cycles,
   output logic [2:0]            state
);
   state_t               state_r, state_nxt;
   logic [NB_ADDR-1:0]   ld_ptr, ptr_nxt;
   logic                 cpu_rst_nxt, cpu_en_nxt, done_nxt, cnt_clr;
   logic                 beat, hlt, ptr_full;

   wire unused_instruc = ^instruc[NB_INSTRUC-NB_OPCODE-1:0];

   assign ld.ld_ready = (state_r == ST_IDLE);
   assign beat        = ld.ld_valid && ld.ld_ready;
   assign ptr_full    = &ld_ptr;
   assign hlt         = cpu_en && (instruc[NB_INSTRUC-1 -: NB_OPCODE] == NB_OPCODE'(OPC_HLT));

   // A clear in the same cycle as a beat drops the word.
   assign pmem_we   = beat && !clear;
   assign pmem_data = pmem_we ? ld.ld_data : '0;
   assign pmem_addr = (state_r == ST_IDLE) ? ld_ptr : pc;
   assign state     = state_r;

   always_comb begin
      state_nxt   = state_r;
      ptr_nxt     = ld_ptr;
      cpu_rst_nxt = cpu_rst;
      cpu_en_nxt  = 1'b0;
      done_nxt    = done;
      cnt_clr     = 1'b0;
      if (clear) begin
         state_nxt   = ST_IDLE;
         ptr_nxt     = '0;
         cpu_rst_nxt = 1'b0;
         done_nxt    = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               cpu_rst_nxt = 1'b0;
               if (beat) begin
                  ptr_nxt = ptr_full ? ld_ptr : ld_ptr + NB_ADDR'(1);
                  if (ld.ld_last || ptr_full) state_nxt = ST_LOADED;
               end
            end
            ST_LOADED: begin
               if (start) begin
                  state_nxt   = step_mode ? ST_STEP : ST_RUN;
                  cpu_rst_nxt = 1'b1;
                  cpu_en_nxt  = !step_mode;
                  cnt_clr     = 1'b1;
                  done_nxt    = 1'b0;
               end
            end
            ST_RUN: begin
               if (hlt) begin
                  state_nxt = ST_HALT;
                  done_nxt  = 1'b1;
               end else begin
                  cpu_rst_nxt = 1'b1;
                  cpu_en_nxt  = 1'b1;
               end
            end
            ST_STEP: begin
               cpu_rst_nxt = 1'b1;
               if (hlt) begin
                  state_nxt = ST_HALT;
                  done_nxt  = 1'b1;
               end else begin
                  cpu_en_nxt = step && !cpu_en;
               end
            end
            ST_HALT: begin
               // Re-run holds the CPU in reset for one cycle so fetch restarts at PC 0.
               if (start) begin
                  state_nxt   = step_mode ? ST_STEP : ST_RUN;
                  cpu_rst_nxt = 1'b0;
                  cnt_clr     = 1'b1;
                  done_nxt    = 1'b0;
               end
            end
            default: begin
               state_nxt   = ST_IDLE;
               ptr_nxt     = '0;
               cpu_rst_nxt = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         ld_ptr  <= '0;
         cpu_rst <= 1'b0;
         cpu_en  <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_r <= state_nxt;
         ld_ptr  <= ptr_nxt;
         cpu_rst <= cpu_rst_nxt;
         cpu_en  <= cpu_en_nxt;
         done    <= done_nxt;
      end
   end

   bip_sat_counter #(.NB_CYCLES(NB_CYCLES)) u_cycles (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (cnt_clr),
      .inc   (cpu_en),
      .count (cycles)
   );
endmodule

// File: tb/tb_bip_run_ctrl.sv
// Directed bench for bip_run_ctrl with a behavioural program memory and PC model.
module tb_bip_run_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, step_mode, step, clear;
   logic [15:0] instruc;
   logic [10:0] pc;
   logic        pmem_we;
   logic [10:0] pmem_addr;
   logic [15:0] pmem_data;
   logic        cpu_rst, cpu_en, done;
   logic [3:0]  cycles;
   logic [2:0]  state;

   int errors = 0;
   int checks = 0;

   logic [15:0] pmem [0:2047];
   int          wr_cnt = 0;
   logic [10:0] last_wr = '0;
   logic [15:0] prog [0:31];

   bip_run_ctrl_if #(.NB_INSTRUC(16)) ld_bus ();

   bip_run_ctrl #(.NB_INSTRUC(16), .NB_OPCODE(5), .NB_ADDR(11), .NB_CYCLES(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ld        (ld_bus.slave),
      .start     (start),
      .step_mode (step_mode),
      .step      (step),
      .clear     (clear),
      .instruc   (instruc),
      .pc        (pc),
      .pmem_we   (pmem_we),
      .pmem_addr (pmem_addr),
      .pmem_data (pmem_data),
      .cpu_rst   (cpu_rst),
      .cpu_en    (cpu_en),
      .done      (done),
      .cycles    (cycles),
      .state     (state)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (pmem_we) begin
         pmem[pmem_addr] <= pmem_data;
         wr_cnt  <= wr_cnt + 1;
         last_wr <= pmem_addr;
      end
   end

   always_ff @(posedge clk or negedge cpu_rst) begin
      if (!cpu_rst)    pc <= '0;
      else if (cpu_en) pc <= pc + 11'd1;
   end
   assign instruc = pmem[pc];

   typedef struct {
      logic        valid;
      logic [15:0] data;
      logic        last;
      logic        exp_we;
      logic [10:0] exp_addr;
      logic [15:0] exp_data;
      logic        exp_ready;
      logic [2:0]  exp_state;
   } ld_vec_t;
   ld_vec_t vecs [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_words(input int n);
      for (int i = 0; i < n; i++) begin
         ld_bus.ld_valid = 1'b1;
         ld_bus.ld_data  = prog[i];
         ld_bus.ld_last  = (i == n - 1);
         tick();
      end
      ld_bus.ld_valid = 1'b0;
      ld_bus.ld_last  = 1'b0;
   endtask

   task automatic pulse_start(input logic mode);
      start     = 1'b1;
      step_mode = mode;
      tick();
      start     = 1'b0;
   endtask

   task automatic wait_done(input int bound, output int ens);
      ens = 0;
      for (int i = 0; i < bound; i++) begin
         if (done) break;
         if (cpu_en) ens++;
         tick();
      end
      chk("done_within_bound", 32'(done), 32'd1);
   endtask

   task automatic step_pulse(input bit hold);
      step = 1'b1;
      tick();
      chk("step_en_high", 32'(cpu_en), 32'd1);
      if (!hold) step = 1'b0;
      tick();
      step = 1'b0;
      chk("step_en_single", 32'(cpu_en), 32'd0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_state"},  32'(state),           32'd0);
      chk({tag, "_ready"},  32'(ld_bus.ld_ready), 32'd1);
      chk({tag, "_we"},     32'(pmem_we),         32'd0);
      chk({tag, "_data"},   32'(pmem_data),       32'd0);
      chk({tag, "_cpurst"}, 32'(cpu_rst),         32'd0);
      chk({tag, "_cpuen"},  32'(cpu_en),          32'd0);
      chk({tag, "_done"},   32'(done),            32'd0);
      chk({tag, "_cycles"}, 32'(cycles),          32'd0);
   endtask

   initial begin
      int ens;
      int wr0;
      vecs[0] = '{1'b1, 16'h0801, 1'b0, 1'b1, 11'd0, 16'h0801, 1'b1, 3'd0};
      vecs[1] = '{1'b0, 16'hBEEF, 1'b0, 1'b0, 11'd1, 16'h0000, 1'b1, 3'd0};
      vecs[2] = '{1'b1, 16'h1002, 1'b0, 1'b1, 11'd1, 16'h1002, 1'b1, 3'd0};
      vecs[3] = '{1'b1, 16'h0000, 1'b1, 1'b1, 11'd2, 16'h0000, 1'b1, 3'd1};
      vecs[4] = '{1'b1, 16'h1234, 1'b0, 1'b0, 11'd0, 16'h0000, 1'b0, 3'd1};

      rst_n = 1'b0; start = 1'b0; step_mode = 1'b0; step = 1'b0; clear = 1'b0;
      ld_bus.ld_valid = 1'b0; ld_bus.ld_data = '0; ld_bus.ld_last = 1'b0;
      #12;
      chk_reset_vals("rst");
      @(negedge clk) rst_n = 1'b1;
      tick();

      // Three-word load, one record per cycle.
      for (int i = 0; i < 5; i++) begin
         ld_bus.ld_valid = vecs[i].valid;
         ld_bus.ld_data  = vecs[i].data;
         ld_bus.ld_last  = vecs[i].last;
         #1;
         chk($sformatf("ld%0d_we", i),    32'(pmem_we),         32'(vecs[i].exp_we));
         chk($sformatf("ld%0d_addr", i),  32'(pmem_addr),       32'(vecs[i].exp_addr));
         chk($sformatf("ld%0d_data", i),  32'(pmem_data),       32'(vecs[i].exp_data));
         chk($sformatf("ld%0d_ready", i), 32'(ld_bus.ld_ready), 32'(vecs[i].exp_ready));
         tick();
         chk($sformatf("ld%0d_state", i), 32'(state),           32'(vecs[i].exp_state));
      end
      ld_bus.ld_valid = 1'b0;
      ld_bus.ld_last  = 1'b0;
      chk("mem0", 32'(pmem[0]), 32'h0801);
      chk("mem1", 32'(pmem[1]), 32'h1002);
      chk("mem2", 32'(pmem[2]), 32'h0000);

      // Continuous run to HLT.
      pulse_start(1'b0);
      chk("run_state",  32'(state),     32'd2);
      chk("run_cpurst", 32'(cpu_rst),   32'd1);
      chk("run_en",     32'(cpu_en),    32'd1);
      chk("run_fetch0", 32'(pmem_addr), 32'd0);
      wait_done(20, ens);
      chk("run_en_cycles", 32'(ens),     32'd3);
      chk("run_cycles",    32'(cycles),  32'd3);
      chk("halt_state",    32'(state),   32'd4);
      chk("halt_en",       32'(cpu_en),  32'd0);
      chk("halt_cpurst",   32'(cpu_rst), 32'd1);
      tick();
      chk("halt_no_more_en", 32'(cpu_en), 32'd0);
      chk("halt_cycles_hold", 32'(cycles), 32'd3);

      // Re-run from HALT in step mode; second step held for two cycles.
      pulse_start(1'b1);
      chk("restart_state",  32'(state),   32'd3);
      chk("restart_cpurst", 32'(cpu_rst), 32'd0);
      chk("restart_cycles", 32'(cycles),  32'd0);
      chk("restart_done",   32'(done),    32'd0);
      tick();
      chk("step_released", 32'(cpu_rst), 32'd1);
      step_pulse(1'b0);
      step_pulse(1'b1);
      chk("step_cycles2", 32'(cycles), 32'd2);
      chk("step_state2",  32'(state),  32'd3);
      step_pulse(1'b0);
      chk("step_halt_state", 32'(state),  32'd4);
      chk("step_halt_done",  32'(done),   32'd1);
      chk("step_cycles3",    32'(cycles), 32'd3);

      // Reload, then clear together with start.
      clear = 1'b1; tick(); clear = 1'b0;
      for (int i = 0; i < 3; i++) prog[i] = vecs[i == 2 ? 3 : (i == 1 ? 2 : 0)].data;
      load_words(3);
      chk("reload_state", 32'(state), 32'd1);
      clear = 1'b1; start = 1'b1; tick(); clear = 1'b0; start = 1'b0;
      chk("clr_state",  32'(state),           32'd0);
      chk("clr_cpurst", 32'(cpu_rst),         32'd0);
      chk("clr_ptr",    32'(pmem_addr),       32'd0);
      chk("clr_ready",  32'(ld_bus.ld_ready), 32'd1);
      chk("clr_en",     32'(cpu_en),          32'd0);

      // 20 non-HLT words then HLT: 21 enable cycles saturate a 4-bit counter.
      for (int i = 0; i < 20; i++) prog[i] = 16'h0800 + 16'(i);
      prog[20] = 16'h0000;
      load_words(21);
      pulse_start(1'b0);
      wait_done(60, ens);
      chk("sat_en_cycles", 32'(ens),    32'd21);
      chk("sat_cycles",    32'(cycles), 32'd15);
      tick(); tick();
      chk("sat_hold", 32'(cycles), 32'd15);

      // Reset in the middle of a run.
      pulse_start(1'b0);
      tick(); tick();
      chk("pre_rst_en", 32'(cpu_en), 32'd1);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("midrun");
      @(negedge clk) rst_n = 1'b1;
      tick();

      // Fill all 2048 words without last.
      wr0 = wr_cnt;
      ld_bus.ld_valid = 1'b1;
      ld_bus.ld_last  = 1'b0;
      for (int i = 0; i < 2048; i++) begin
         ld_bus.ld_data = 16'(i) | 16'h0800;
         tick();
      end
      chk("full_writes", 32'(wr_cnt - wr0), 32'd2048);
      chk("full_last",   32'(last_wr),       32'h7FF);
      chk("full_state",  32'(state),         32'd1);
      chk("full_ready",  32'(ld_bus.ld_ready), 32'd0);
      chk("full_no_we",  32'(pmem_we),       32'd0);
      tick();
      chk("full_no_extra", 32'(wr_cnt - wr0), 32'd2048);
      ld_bus.ld_valid = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
